// File: rtl/imm_gen_pipe.sv
// Registered RV32/RV64 immediate generator with a 2-entry skid buffer and a saturating illegal-select counter.
// Optional feature: define IMM_ZICSR_EN to decode select 101 as the CSR zimm (zero-extended rs1 field).
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic             r_m_valid;
  logic [XLEN-1:0]  r_m_imm;
  logic [TAG_W-1:0] r_m_tag;
  logic             r_m_ill;

  logic             r_k_valid;
  logic [XLEN-1:0]  r_k_imm;
  logic [TAG_W-1:0] r_k_tag;
  logic             r_k_ill;

  logic [CNT_W-1:0] r_cnt;

  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_in_xfer;
  logic             w_out_xfer;

  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (in_immsrc)
      3'b000: w_imm = XLEN'($signed(in_instr[31:20]));
      3'b001: w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      3'b010: w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
      3'b011: w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));
      3'b100: w_imm = XLEN'($signed({in_instr[31:12], 12'h000}));
`ifdef IMM_ZICSR_EN
      3'b101: w_imm = XLEN'(in_instr[19:15]);
`endif
      default: w_ill = 1'b1;
    endcase
  end

  // in_ready is the registered complement of K occupancy, so no out_ready path exists.
  assign in_ready   = ~r_k_valid;
  assign w_in_xfer  = in_valid & in_ready & ~flush;
  assign w_out_xfer = r_m_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_m_imm   <= '0;
      r_m_tag   <= '0;
      r_m_ill   <= 1'b0;
      r_k_valid <= 1'b0;
      r_k_imm   <= '0;
      r_k_tag   <= '0;
      r_k_ill   <= 1'b0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_m_imm   <= '0;
      r_m_tag   <= '0;
      r_m_ill   <= 1'b0;
      r_k_valid <= 1'b0;
      r_k_imm   <= '0;
      r_k_tag   <= '0;
      r_k_ill   <= 1'b0;
    end else if (w_out_xfer && r_k_valid) begin
      // K full implies in_ready=0, so no input can arrive here.
      r_m_imm   <= r_k_imm;
      r_m_tag   <= r_k_tag;
      r_m_ill   <= r_k_ill;
      r_k_valid <= 1'b0;
    end else if (w_in_xfer && (!r_m_valid || w_out_xfer)) begin
      r_m_valid <= 1'b1;
      r_m_imm   <= w_imm;
      r_m_tag   <= in_tag;
      r_m_ill   <= w_ill;
    end else if (w_in_xfer) begin
      r_k_valid <= 1'b1;
      r_k_imm   <= w_imm;
      r_k_tag   <= in_tag;
      r_k_ill   <= w_ill;
    end else if (w_out_xfer) begin
      r_m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_in_xfer && w_ill && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid   = r_m_valid;
  assign out_imm     = r_m_imm;
  assign out_tag     = r_m_tag;
  assign out_illegal = r_m_ill;
  assign illegal_cnt = r_cnt;

endmodule
